// File: rtl/lpgbt_uplink_pkg.sv
// rtl/lpgbt_uplink_pkg.sv - shared types and constants for the lpGBT uplink frame packer
package lpgbt_uplink_pkg;

    localparam int FRAME_W       = 234;
    localparam int WORD_W        = 32;
    localparam int SEQ_W         = 16;
    localparam int WORDS_PER_PKT = 9;
    localparam logic [3:0] LAST_IDX  = 4'(WORDS_PER_PKT - 1);
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // One buffered frame: sequence tag, FEC flag and raw uplink user data
    typedef struct packed {
        logic [SEQ_W-1:0]   seq;
        logic               fec;
        logic [FRAME_W-1:0] data;
    } uplink_frame_t;

    localparam int ENTRY_W = $bits(uplink_frame_t);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } pack_state_t;

    // Word idx of a packet: 0 is the header, 1..8 are data slices zero-padded above bit 233
    function automatic logic [WORD_W-1:0] pack_word(input uplink_frame_t f, input logic [3:0] idx);
        logic [WORD_W*(WORDS_PER_PKT-1)-1:0] padded;
        logic [WORD_W-1:0]                   w;
        padded              = '0;
        padded[FRAME_W-1:0] = f.data;
        w                   = {HDR_MAGIC, f.fec, 7'b0, f.seq};
        for (int k = 1; k < WORDS_PER_PKT; k++) begin
            if (idx == k[3:0]) begin
                w = padded[WORD_W*(k-1) +: WORD_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lpgbt_uplink_frame_packer_fifo.sv
// rtl/lpgbt_uplink_frame_packer_fifo.sv - single-clock frame FIFO with registered read data and flush
module sync_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered read port; holds the last popped entry untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (do_rd) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/lpgbt_uplink_frame_packer.sv
// rtl/lpgbt_uplink_frame_packer.sv - samples uplink frames, buffers them and streams 9-word packets
module lpgbt_uplink_frame_packer
    import lpgbt_uplink_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk40,
    input  logic                          aresetn,
    input  logic                          uplinkrdy_i,
    input  logic [FRAME_W-1:0]            uplinkUserData_i,
    input  logic                          uplinkFEC_i,
    input  logic                          capture_en_i,
    input  logic [15:0]                   decimate_i,
    input  logic                          clear_i,
    output logic [WORD_W-1:0]             m_tdata_o,
    output logic                          m_tvalid_o,
    output logic                          m_tlast_o,
    input  logic                          m_tready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [15:0]                   fec_cnt_o,
    output logic [15:0]                   seq_o
);

    logic          gate;
    logic          eligible;
    logic          push;
    logic          pop;
    logic          hs;
    logic          last_hs;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   dec_cnt;
    uplink_frame_t wr_frame;
    uplink_frame_t hold;
    pack_state_t   state;
    logic [3:0]    idx;

    assign gate     = capture_en_i && uplinkrdy_i;
    assign eligible = gate && (dec_cnt == 16'd0);
    assign push     = eligible && !fifo_full && !clear_i;
    assign hs       = m_tvalid_o && m_tready_i;
    assign last_hs  = hs && (idx == LAST_IDX);
    // clear wins over pop so a flushed frame never leaks out as a new packet
    assign pop      = !clear_i && !fifo_empty && ((state == ST_IDLE) || last_hs);

    assign wr_frame.seq  = seq_o;
    assign wr_frame.fec  = uplinkFEC_i;
    assign wr_frame.data = uplinkUserData_i;

    sync_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk40),
        .rst_n   (aresetn),
        .flush   (clear_i),
        .wr_en   (push),
        .wr_data (wr_frame),
        .rd_en   (pop),
        .rd_data (hold),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    // Decimation phase: runs 0..decimate_i while capture is gated on, parked at 0 otherwise
    always_ff @(posedge clk40 or negedge aresetn) begin
        if (!aresetn) begin
            dec_cnt <= '0;
        end else if (clear_i || !gate || (dec_cnt == decimate_i)) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 16'd1;
        end
    end

    // Sequence number advances on every eligible frame, pushed or dropped, and wraps
    always_ff @(posedge clk40 or negedge aresetn) begin
        if (!aresetn) begin
            seq_o <= '0;
        end else if (clear_i) begin
            seq_o <= '0;
        end else if (eligible) begin
            seq_o <= seq_o + 16'd1;
        end
    end

    // Saturating count of eligible frames lost to a full FIFO
    always_ff @(posedge clk40 or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            drop_cnt_o <= '0;
        end else if (eligible && fifo_full && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    // Saturating count of FEC-corrected frames on a ready link, regardless of capture
    always_ff @(posedge clk40 or negedge aresetn) begin
        if (!aresetn) begin
            fec_cnt_o <= '0;
        end else if (clear_i) begin
            fec_cnt_o <= '0;
        end else if (uplinkrdy_i && uplinkFEC_i && (fec_cnt_o != 16'hFFFF)) begin
            fec_cnt_o <= fec_cnt_o + 16'd1;
        end
    end

    // Packet FSM: pops a frame into the hold register and walks header + 8 data words
    always_ff @(posedge clk40 or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_SEND;
                        idx        <= '0;
                        m_tvalid_o <= 1'b1;
                        m_tlast_o  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            m_tlast_o <= 1'b0;
                            if (!pop) begin
                                state      <= ST_IDLE;
                                m_tvalid_o <= 1'b0;
                            end
                        end else begin
                            idx       <= idx + 4'd1;
                            m_tlast_o <= ((idx + 4'd1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    idx        <= '0;
                    m_tvalid_o <= 1'b0;
                    m_tlast_o  <= 1'b0;
                end
            endcase
        end
    end

    // Word mux off the hold register; forced to zero outside a packet
    always_comb begin
        m_tdata_o = '0;
        if (m_tvalid_o) begin
            m_tdata_o = pack_word(hold, idx);
        end
    end

endmodule

// File: tb/tb_lpgbt_uplink_frame_packer.sv
// tb/tb_lpgbt_uplink_frame_packer.sv - directed self-checking bench for the uplink frame packer
module tb_lpgbt_uplink_frame_packer;

    logic          clk40 = 1'b0;
    logic          aresetn;
    logic          uplinkrdy_i;
    logic [233:0]  uplinkUserData_i;
    logic          uplinkFEC_i;
    logic          capture_en_i;
    logic [15:0]   decimate_i;
    logic          clear_i;
    logic [31:0]   m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tlast_o;
    logic          m_tready_i;
    logic [4:0]    fifo_level_o;
    logic [15:0]   drop_cnt_o;
    logic [15:0]   fec_cnt_o;
    logic [15:0]   seq_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wq[$];
    logic        lq[$];
    int          tq[$];
    logic [31:0] exp_w[$];
    logic        stalled = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;
    logic [233:0] d;

    lpgbt_uplink_frame_packer #(.FIFO_DEPTH(16)) dut (
        .clk40            (clk40),
        .aresetn          (aresetn),
        .uplinkrdy_i      (uplinkrdy_i),
        .uplinkUserData_i (uplinkUserData_i),
        .uplinkFEC_i      (uplinkFEC_i),
        .capture_en_i     (capture_en_i),
        .decimate_i       (decimate_i),
        .clear_i          (clear_i),
        .m_tdata_o        (m_tdata_o),
        .m_tvalid_o       (m_tvalid_o),
        .m_tlast_o        (m_tlast_o),
        .m_tready_i       (m_tready_i),
        .fifo_level_o     (fifo_level_o),
        .drop_cnt_o       (drop_cnt_o),
        .fec_cnt_o        (fec_cnt_o),
        .seq_o            (seq_o)
    );

    always #5 clk40 = ~clk40;

    always @(posedge clk40) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collects handshaken words mid-cycle and checks stability while stalled
    always @(negedge clk40) begin
        if (aresetn && m_tvalid_o) begin
            if (stalled) begin
                check("stall_tdata", {31'b0, m_tlast_o, m_tdata_o}, {31'b0, stall_last, stall_data});
            end
            if (m_tready_i) begin
                wq.push_back(m_tdata_o);
                lq.push_back(m_tlast_o);
                tq.push_back(cyc);
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                stall_data = m_tdata_o;
                stall_last = m_tlast_o;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        lq.delete();
        tq.delete();
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++) step();
        check("word_count", wq.size(), n);
    endtask

    initial begin
        aresetn          = 1'b0;
        uplinkrdy_i      = 1'b0;
        uplinkUserData_i = '0;
        uplinkFEC_i      = 1'b0;
        capture_en_i     = 1'b0;
        decimate_i       = '0;
        clear_i          = 1'b0;
        m_tready_i       = 1'b0;
        repeat (3) step();
        check("rst_outputs", {m_tdata_o, m_tvalid_o, m_tlast_o, fifo_level_o}, 64'h0);
        check("rst_counters", {drop_cnt_o, fec_cnt_o, seq_o}, 64'h0);
        aresetn = 1'b1;
        step();

        // capture basic: three back-to-back frames
        uplinkrdy_i  = 1'b1;
        m_tready_i   = 1'b1;
        capture_en_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            uplinkUserData_i = 234'(i);
            step();
        end
        capture_en_i = 1'b0;
        wait_words(27, 100);
        for (int p = 0; p < 3; p++) begin
            check("basic_hdr", wq[9*p], 32'hA500_0000 + 32'(p));
            check("basic_w1", wq[9*p+1], 32'(p + 1));
        end
        check("basic_w2_zero", wq[2], 32'h0);
        for (int i = 0; i < 27; i++) check("basic_tlast", lq[i], (i % 9) == 8);
        check("basic_no_gap", tq[26] - tq[0], 26);
        check("basic_seq", seq_o, 16'd3);

        // FEC counting gated by uplink ready, then a captured FEC frame
        uplinkFEC_i = 1'b1;
        repeat (5) step();
        uplinkrdy_i = 1'b0;
        repeat (3) step();
        uplinkFEC_i = 1'b0;
        check("fec_cnt5", fec_cnt_o, 16'd5);
        clear_mon();
        d              = '0;
        d[233:224]     = 10'h2AB;
        d[31:0]        = 32'hCAFE_F00D;
        uplinkUserData_i = d;
        uplinkrdy_i    = 1'b1;
        capture_en_i   = 1'b1;
        uplinkFEC_i    = 1'b1;
        step();
        capture_en_i   = 1'b0;
        uplinkFEC_i    = 1'b0;
        check("fec_cnt6", fec_cnt_o, 16'd6);
        wait_words(9, 40);
        check("fec_hdr", wq[0], 32'hA580_0003);
        check("fec_w1", wq[1], 32'hCAFE_F00D);
        check("fec_w8_pad", wq[8], 32'h0000_02AB);

        // decimation by 4 over 16 gated cycles
        repeat (2) step();
        pulse_clear();
        clear_mon();
        decimate_i   = 16'd3;
        capture_en_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            uplinkUserData_i = 234'(c);
            step();
        end
        capture_en_i = 1'b0;
        check("dec_seq", seq_o, 16'd4);
        wait_words(36, 80);
        for (int j = 0; j < 4; j++) begin
            check("dec_hdr", wq[9*j], 32'hA500_0000 + 32'(j));
            check("dec_w1", wq[9*j+1], 32'(4 * j));
        end
        repeat (20) step();
        check("dec_extra", wq.size(), 36);
        decimate_i = 16'd0;

        // overflow: one frame parked in SEND, then 20 frames into a 16-deep FIFO
        pulse_clear();
        clear_mon();
        m_tready_i       = 1'b0;
        uplinkUserData_i = 234'hBEEF;
        capture_en_i     = 1'b1;
        step();
        capture_en_i     = 1'b0;
        repeat (3) step();
        check("ovf_parked", m_tvalid_o, 1'b1);
        pulse_clear();
        capture_en_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            uplinkUserData_i = 234'(k);
            step();
        end
        capture_en_i = 1'b0;
        step();
        check("ovf_level", fifo_level_o, 5'd16);
        check("ovf_drop", drop_cnt_o, 16'd4);
        check("ovf_seq", seq_o, 16'd20);
        m_tready_i = 1'b1;
        wait_words(153, 400);
        check("ovf_parked_hdr", wq[0], 32'hA500_0000);
        check("ovf_parked_w1", wq[1], 32'h0000_BEEF);
        for (int k = 0; k < 16; k++) begin
            check("ovf_hdr", wq[9*(k+1)], 32'hA500_0000 + 32'(k));
            check("ovf_w1", wq[9*(k+1)+1], 32'(k));
        end
        step();
        check("ovf_drained", fifo_level_o, 5'd0);

        // backpressure: tready toggles every cycle
        pulse_clear();
        clear_mon();
        exp_w.delete();
        m_tready_i   = 1'b0;
        capture_en_i = 1'b1;
        for (int f = 0; f < 2; f++) begin
            d = '0;
            exp_w.push_back(32'hA500_0000 + 32'(f));
            for (int w = 1; w <= 7; w++) begin
                d[32*(w-1) +: 32] = {8'(f + 1), 8'(w), 16'h5A5A};
                exp_w.push_back({8'(f + 1), 8'(w), 16'h5A5A});
            end
            d[233:224] = 10'h100 + 10'(f);
            exp_w.push_back(32'h0000_0100 + 32'(f));
            uplinkUserData_i = d;
            step();
        end
        capture_en_i = 1'b0;
        for (int i = 0; i < 120 && wq.size() < 18; i++) begin
            m_tready_i = ~m_tready_i;
            step();
        end
        check("bp_words", wq.size(), 18);
        for (int i = 0; i < 18; i++) begin
            check("bp_data", wq[i], exp_w[i]);
            check("bp_tlast", lq[i], (i % 9) == 8);
        end

        // clear mid-packet with three frames queued behind it
        m_tready_i = 1'b1;
        repeat (3) step();
        pulse_clear();
        clear_mon();
        capture_en_i = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            uplinkUserData_i = 234'(k);
            step();
        end
        capture_en_i = 1'b0;
        for (int i = 0; i < 30 && wq.size() < 4; i++) step();
        check("clr_started", wq.size() >= 4 && wq.size() < 9, 1'b1);
        pulse_clear();
        repeat (30) step();
        check("clr_words", wq.size(), 9);
        check("clr_hdr", wq[0], 32'hA500_0000);
        check("clr_w1", wq[1], 32'd7);
        check("clr_tlast", lq[8], 1'b1);
        check("clr_idle", {m_tvalid_o, fifo_level_o}, 64'h0);
        check("clr_counters", {drop_cnt_o, fec_cnt_o, seq_o}, 64'h0);

        // async reset mid-packet drops tvalid at once
        uplinkUserData_i = 234'h5;
        capture_en_i     = 1'b1;
        step();
        capture_en_i     = 1'b0;
        repeat (3) step();
        check("ars_active", m_tvalid_o, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("ars_tvalid", {m_tvalid_o, m_tdata_o}, 64'h0);
        check("ars_state", {fifo_level_o, seq_o}, 64'h0);
        step();
        aresetn = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
